pattern_detector: RTL and testbench

Parametrised serial bit-pattern detector, the successor of the fixed-sequence detector. It replaces the hard-coded sequence with a run-time programmable pattern of `PAT_LEN` bits. It adds a selectable overlap or non-overlap mode and a saturating match counter. It sits on the same single-bit, valid-qualified serial stream and flags each complete occurrence of the pattern with a one-cycle pulse.

---
 rtl/pattern_detector.sv | 53 +++++
 tb/tb_pattern_detector.sv | 118 +++++++++++
 2 files changed

// File: rtl/pattern_detector.sv
// pattern_detector: programmable serial pattern matcher with overlap mode and saturating match counter
module pattern_detector #(
  parameter int PAT_LEN = 5,
  parameter int CNT_W = 8,
  parameter logic [PAT_LEN-1:0] PAT_DEFAULT = 5'b11011,
  parameter logic OVL_DEFAULT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_vld,
  input  logic               din,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               result,
  output logic [CNT_W-1:0]   match_cnt
);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  logic [PAT_LEN-1:0] hist, hist_n, hist_d, pat_r;
  logic [FW-1:0] fill, fill_n, fill_d;
  logic [CNT_W-1:0] cnt_base, cnt_d;
  logic ovl_r, acc, hit;
  always_comb begin
    acc = din_vld && !cfg_we;
    hist_n = {hist[PAT_LEN-2:0], din};
    hist_d = acc ? hist_n : hist;
    fill_n = (fill == FULL) ? FULL : fill + 1'b1;
    hit = acc && (fill_n == FULL) && (hist_n == pat_r);
    // non-overlap restarts the fill so bits of a found match are never reused
    fill_d = cfg_we ? '0 : !acc ? fill : hit ? (ovl_r ? FULL : '0) : fill_n;
    cnt_base = clr_cnt ? '0 : match_cnt;
    cnt_d = (hit && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
      pat_r <= PAT_DEFAULT;
      ovl_r <= OVL_DEFAULT;
      result <= 1'b0;
      match_cnt <= '0;
    end else begin
      hist <= hist_d;
      fill <= fill_d;
      pat_r <= cfg_we ? cfg_pattern : pat_r;
      ovl_r <= cfg_we ? cfg_overlap : ovl_r;
      result <= hit;
      match_cnt <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: directed checks of matching, overlap, gaps, reset, reconfiguration and saturation
module tb_pattern_detector;
  logic clk = 0, rst_n = 1, din_vld = 0, din = 0, cfg_we = 0, cfg_overlap = 0, clr_cnt = 0;
  logic [4:0] cfg_pattern = 5'b11011;
  logic result, result2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  pattern_detector dut (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .result(result), .match_cnt(match_cnt)
  );
  pattern_detector #(.CNT_W(2), .PAT_DEFAULT(5'b11111), .OVL_DEFAULT(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .result(result2), .match_cnt(match_cnt2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input logic v, input logic d, input logic we, input logic clr);
    din_vld = v;
    din = d;
    cfg_we = we;
    clr_cnt = clr;
    @(posedge clk);
    #1;
    din_vld = 0;
    cfg_we = 0;
    clr_cnt = 0;
  endtask
  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] exp, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, bits[n-1-i], 1'b0, 1'b0);
      chk(tag, 32'(result), 32'(exp[n-1-i]));
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    #2;
    chk("rst_result", 32'(result), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_result2", 32'(result2), 0);
    chk("rst_cnt2", 32'(match_cnt2), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  initial begin
    #1;
    do_reset();
    stream(16'b11011011, 8, 16'b00001001, "ovl_stream");
    chk("ovl_cnt", 32'(match_cnt), 2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_result", 32'(result), 0);
    cfg_pattern = 5'b11011;
    cfg_overlap = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("cfg_result", 32'(result), 0);
    chk("cfg_clr_cnt", 32'(match_cnt), 0);
    stream(16'b11011011, 8, 16'b00001000, "novl_stream");
    chk("novl_cnt", 32'(match_cnt), 1);
    cfg_overlap = 1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("cfg2_cnt", 32'(match_cnt), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_b1", 32'(result), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_b2", 32'(result), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_g1", 32'(result), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("gap_b3", 32'(result), 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("gap_g2", 32'(result), 0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_b4", 32'(result), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_g3", 32'(result), 0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_b5", 32'(result), 1);
    chk("gap_cnt", 32'(match_cnt), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_after", 32'(result), 0);
    stream(16'b110, 3, 16'b000, "pre_rst");
    do_reset();
    stream(16'b11, 2, 16'b00, "post_rst");
    chk("post_rst_cnt", 32'(match_cnt), 0);
    do_reset();
    stream(16'b1101, 4, 16'b0000, "cfgmid_pre");
    cfg_pattern = 5'b11011;
    cfg_overlap = 1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("cfgmid_we", 32'(result), 0);
    stream(16'b11011, 5, 16'b00001, "cfgmid_post");
    chk("cfgmid_cnt", 32'(match_cnt), 1);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("sat_result", 32'(result2), 32'(i >= 4));
      chk("sat_cnt", 32'(match_cnt2), (i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3));
      chk("sat_other", 32'(result), 0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_hit_result", 32'(result2), 1);
    chk("clr_hit_cnt", 32'(match_cnt2), 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
